ddr_rd_arbiter: RTL

//  Shares the single DDR AXI read port (AR + R) between the demand path (port 0) and the prefetcher (port 1).

---
 rtl/ddr_rd_arbiter.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/ddr_rd_arbiter.sv
// DDR AXI read-port arbiter: demand (s0) vs prefetch (s1) with a prefetch starvation guard,
// and issue-order tracking to route R beats back. Optional perf counters under ARB_PERF_CNT_EN.
module ddr_rd_arbiter #(
  parameter int ADDR_BITS       = 16,
  parameter int BURST_LEN_WIDTH = 8,
  parameter int TID_WIDTH       = 8,
  parameter int DATA_WIDTH      = 8,
  parameter int LOG_OUTSTANDING = 3,
  parameter int STARVE_WIDTH    = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s0_ar_valid,
  output logic                       s0_ar_ready,
  input  logic [ADDR_BITS-1:0]       s0_ar_addr,
  input  logic [BURST_LEN_WIDTH-1:0] s0_ar_len,
  input  logic [TID_WIDTH-1:0]       s0_ar_id,
  input  logic                       s1_ar_valid,
  output logic                       s1_ar_ready,
  input  logic [ADDR_BITS-1:0]       s1_ar_addr,
  input  logic [BURST_LEN_WIDTH-1:0] s1_ar_len,
  input  logic [TID_WIDTH-1:0]       s1_ar_id,
  output logic                       m_ar_valid,
  input  logic                       m_ar_ready,
  output logic [ADDR_BITS-1:0]       m_ar_addr,
  output logic [BURST_LEN_WIDTH-1:0] m_ar_len,
  output logic [TID_WIDTH-1:0]       m_ar_id,
  input  logic                       m_r_valid,
  output logic                       m_r_ready,
  input  logic                       m_r_last,
  input  logic [DATA_WIDTH-1:0]      m_r_data,
  input  logic [TID_WIDTH-1:0]       m_r_id,
  output logic                       s0_r_valid,
  input  logic                       s0_r_ready,
  output logic                       s0_r_last,
  output logic [DATA_WIDTH-1:0]      s0_r_data,
  output logic [TID_WIDTH-1:0]       s0_r_id,
  output logic                       s1_r_valid,
  input  logic                       s1_r_ready,
  output logic                       s1_r_last,
  output logic [DATA_WIDTH-1:0]      s1_r_data,
  output logic [TID_WIDTH-1:0]       s1_r_id,
  input  logic [STARVE_WIDTH-1:0]    crs_starveLimit,
  output logic [LOG_OUTSTANDING:0]   outstandingCnt,
`ifdef ARB_PERF_CNT_EN
  output logic [15:0]                perfDemandCnt,
  output logic [15:0]                perfPrefetchCnt,
  output logic [15:0]                perfStarveGrants,
`endif
  output logic                       errUnexpR
);

  localparam int DEPTH = 2 ** LOG_OUTSTANDING;
  localparam logic [LOG_OUTSTANDING:0] FULL_CNT = DEPTH[LOG_OUTSTANDING:0];
  localparam logic [STARVE_WIDTH-1:0] STARVE_ZERO = {STARVE_WIDTH{1'b0}};
  localparam logic [STARVE_WIDTH-1:0] STARVE_MAX  = {STARVE_WIDTH{1'b1}};
  localparam logic [STARVE_WIDTH-1:0] STARVE_ONE  = {{(STARVE_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t                     state_r, state_next_s;
  logic [STARVE_WIDTH-1:0]    starve_r;
  logic                       order_mem_r [DEPTH];
  logic [LOG_OUTSTANDING-1:0] wr_ptr_r, rd_ptr_r;
  logic [LOG_OUTSTANDING:0]   cnt_r;
  logic                       full_s, empty_s, accept_s, grant_s1_s, starve_hit_s;
  logic                       push_s, pop_s, sel_s;

  assign full_s       = (cnt_r == FULL_CNT);
  assign empty_s      = (cnt_r == {(LOG_OUTSTANDING+1){1'b0}});
  assign accept_s     = (state_r == IDLE) && !full_s && (s0_ar_valid || s1_ar_valid);
  assign starve_hit_s = (crs_starveLimit != STARVE_ZERO) && (starve_r >= crs_starveLimit);
  // Guard overrides demand only once prefetch has waited long enough; otherwise demand first.
  assign grant_s1_s   = (starve_hit_s && s1_ar_valid) || !s0_ar_valid;
  assign push_s       = accept_s;
  assign sel_s        = order_mem_r[rd_ptr_r];
  assign pop_s        = m_r_valid && m_r_ready && m_r_last;
  assign outstandingCnt = cnt_r;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_next_s;
  end

  // FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_next_s = ISSUE;
        else          state_next_s = IDLE;
      end
      ISSUE: begin
        if (m_ar_ready) state_next_s = IDLE;
        else            state_next_s = ISSUE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM outputs: AR valid from state, single-cycle accept pulse to the winner
  always_comb begin
    m_ar_valid  = 1'b0;
    s0_ar_ready = 1'b0;
    s1_ar_ready = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          s0_ar_ready = !grant_s1_s;
          s1_ar_ready = grant_s1_s;
        end else begin
          s0_ar_ready = 1'b0;
          s1_ar_ready = 1'b0;
        end
      end
      ISSUE:   m_ar_valid = 1'b1;
      default: m_ar_valid = 1'b0;
    endcase
  end

  // AR payload capture on accept; held stable while issuing
  always_ff @(posedge clk) begin
    if (rst) begin
      m_ar_addr <= {ADDR_BITS{1'b0}};
      m_ar_len  <= {BURST_LEN_WIDTH{1'b0}};
      m_ar_id   <= {TID_WIDTH{1'b0}};
    end else if (accept_s) begin
      m_ar_addr <= grant_s1_s ? s1_ar_addr : s0_ar_addr;
      m_ar_len  <= grant_s1_s ? s1_ar_len  : s0_ar_len;
      m_ar_id   <= grant_s1_s ? s1_ar_id   : s0_ar_id;
    end
  end

  // Prefetch starvation counter (saturating)
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_r <= STARVE_ZERO;
    end else if (s1_ar_valid && !(accept_s && grant_s1_s)) begin
      if (starve_r != STARVE_MAX) starve_r <= starve_r + STARVE_ONE;
    end else begin
      starve_r <= STARVE_ZERO;
    end
  end

  // Issue-order FIFO: one source bit per accepted burst, popped on the burst's last beat
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {LOG_OUTSTANDING{1'b0}};
      rd_ptr_r <= {LOG_OUTSTANDING{1'b0}};
      cnt_r    <= {(LOG_OUTSTANDING+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) order_mem_r[i] <= 1'b0;
    end else begin
      if (push_s) begin
        order_mem_r[wr_ptr_r] <= grant_s1_s;
        wr_ptr_r              <= wr_ptr_r + {{(LOG_OUTSTANDING-1){1'b0}}, 1'b1};
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + {{(LOG_OUTSTANDING-1){1'b0}}, 1'b1};
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + {{LOG_OUTSTANDING{1'b0}}, 1'b1};
        2'b01:   cnt_r <= cnt_r - {{LOG_OUTSTANDING{1'b0}}, 1'b1};
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // R routing to the source at the FIFO head; beats with nothing outstanding stall
  always_comb begin
    s0_r_valid = 1'b0;
    s1_r_valid = 1'b0;
    m_r_ready  = 1'b0;
    if (!empty_s) begin
      s0_r_valid = m_r_valid && !sel_s;
      s1_r_valid = m_r_valid && sel_s;
      m_r_ready  = sel_s ? s1_r_ready : s0_r_ready;
    end else begin
      s0_r_valid = 1'b0;
      s1_r_valid = 1'b0;
      m_r_ready  = 1'b0;
    end
  end

  assign s0_r_last = m_r_last;
  assign s0_r_data = m_r_data;
  assign s0_r_id   = m_r_id;
  assign s1_r_last = m_r_last;
  assign s1_r_data = m_r_data;
  assign s1_r_id   = m_r_id;

  // Sticky unexpected-beat flag
  always_ff @(posedge clk) begin
    if (rst)                       errUnexpR <= 1'b0;
    else if (m_r_valid && empty_s) errUnexpR <= 1'b1;
    else                           errUnexpR <= errUnexpR;
  end

`ifdef ARB_PERF_CNT_EN
  // Saturating grant counters; starve grants count only where demand was overridden
  always_ff @(posedge clk) begin
    if (rst) begin
      perfDemandCnt    <= 16'h0000;
      perfPrefetchCnt  <= 16'h0000;
      perfStarveGrants <= 16'h0000;
    end else if (accept_s) begin
      if (!grant_s1_s && perfDemandCnt != 16'hFFFF)  perfDemandCnt   <= perfDemandCnt + 16'h0001;
      if (grant_s1_s && perfPrefetchCnt != 16'hFFFF) perfPrefetchCnt <= perfPrefetchCnt + 16'h0001;
      if (grant_s1_s && s0_ar_valid && perfStarveGrants != 16'hFFFF)
        perfStarveGrants <= perfStarveGrants + 16'h0001;
    end else begin
      perfDemandCnt    <= perfDemandCnt;
      perfPrefetchCnt  <= perfPrefetchCnt;
      perfStarveGrants <= perfStarveGrants;
    end
  end
`endif

endmodule
